// File: rtl/mem_word_ctrl.sv
// mem_word_ctrl: serialises byte/half/word host requests into
// little-endian single-byte beats on a 1-cycle-latency byte memory.
// Ports: clk, rst (async, active-high);
//   host req_*  : valid/ready request (write, size, addr, wdata)
//   host rsp_*  : valid/ready response (rdata, err)
//   memory mem_*: we, addr, wdata out; rdata in (1 cycle after addr)
// Option: MEM_CTRL_ALIGN_CHECK_EN rejects misaligned/reserved-size
//   requests with rsp_err; when undefined rsp_err stays 0.
module mem_word_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*WORD_BYTES-1:0] req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata
);

  localparam int DW    = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(WORD_BYTES + 1);
  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_RLAST = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  n_bytes;
  // cnt = number of beats already issued
  logic [CNT_W-1:0]  cnt;
  logic [DW-1:0]     wbuf;

  logic [ADDR_W-1:0] beat_addr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  cap_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [CNT_W-1:0]  req_n;
  logic              reject;

  function automatic logic [CNT_W-1:0] size_bytes(
    input logic [1:0] s
  );
    logic [CNT_W-1:0] r;
    case (s)
      2'b00:   r = CNT_W'(1);
      2'b01:   r = CNT_W'(2);
      default: r = CNT_W'(WORD_BYTES);
    endcase
    return r;
  endfunction

  assign req_ready = (state == S_IDLE);
  assign req_n     = size_bytes(req_size);
  assign beat_addr = base + ADDR_W'(cnt);
  assign wr_idx    = cnt[IDX_W-1:0];
  // read data for beat k arrives while beat k+1 is being issued
  assign cap_idx   = IDX_W'(cnt - CNT_W'(2));
  assign last_idx  = IDX_W'(cnt - CNT_W'(1));

`ifdef MEM_CTRL_ALIGN_CHECK_EN
  assign reject = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && (req_addr[1:0] != 2'b00));
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      base      <= '0;
      n_bytes   <= '0;
      cnt       <= '0;
      wbuf      <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            base      <= req_addr;
            n_bytes   <= req_n;
            wbuf      <= req_wdata;
            rsp_rdata <= '0;
            if (reject) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end else begin
              // first beat goes out in the cycle after accept
              mem_we   <= req_write;
              mem_addr <= req_addr;
              if (req_write) mem_wdata <= req_wdata[7:0];
              cnt      <= CNT_W'(1);
              state    <= req_write ? S_WR : S_RD;
            end
          end
        end
        S_WR: begin
          if (cnt == n_bytes) begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            mem_addr  <= beat_addr;
            mem_wdata <= wbuf[{wr_idx, 3'b000} +: 8];
            cnt       <= cnt + CNT_W'(1);
          end
        end
        S_RD: begin
          if (cnt >= CNT_W'(2))
            rsp_rdata[{cap_idx, 3'b000} +: 8] <= mem_rdata;
          if (cnt == n_bytes) begin
            state <= S_RLAST;
          end else begin
            mem_addr <= beat_addr;
            cnt      <= cnt + CNT_W'(1);
          end
        end
        S_RLAST: begin
          rsp_rdata[{last_idx, 3'b000} +: 8] <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// tb_mem_word_ctrl: directed bench for mem_word_ctrl with a
// 256 x 8 synchronous byte memory model attached.
module tb_mem_word_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  mem_word_ctrl #(.ADDR_W(8), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int nchk  = 0;
  int nfail = 0;

  logic        bwe  [0:7];
  logic [7:0]  badr [0:7];
  logic [7:0]  bwd  [0:7];
  int          lat;
  logic [31:0] rd;
  logic        er;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge; return at the negedge where
  // rsp_valid is first seen (lat = cycle number, cycle 0 = accept).
  task automatic run(input logic w, input logic [1:0] sz,
                     input logic [7:0] a, input logic [31:0] wd);
    for (int i = 0; i < 8; i++) begin
      bwe[i]  = 1'b0;
      badr[i] = 8'h00;
      bwd[i]  = 8'h00;
    end
    lat = -1;
    rd  = 32'hxxxxxxxx;
    er  = 1'bx;
    req_write = w;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c < 8) begin
        bwe[c]  = mem_we;
        badr[c] = mem_addr;
        bwd[c]  = mem_wdata;
      end
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
  endtask

  task automatic done_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_vld_drop"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(req_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'b00;
    req_addr  = 8'h00;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // word write DDCCBBAA @10
    run(1'b1, 2'b10, 8'h10, 32'hDDCCBBAA);
    chk("t1w_lat", 32'(lat), 32'd5);
    chk("t1w_rdata", rd, 32'd0);
    chk("t1w_err", 32'(er), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("t1w_we",   32'(bwe[k+1]),  32'd1);
      chk("t1w_addr", 32'(badr[k+1]), 32'(8'h10 + k));
      chk("t1w_data", 32'(bwd[k+1]),  32'(8'hAA + 8'h11 * k));
    end
    chk("t1w_we_off", 32'(mem_we), 32'd0);
    done_rsp("t1w");

    // word read @10
    run(1'b0, 2'b10, 8'h10, 32'h0);
    chk("t1r_lat", 32'(lat), 32'd6);
    chk("t1r_rdata", rd, 32'hDDCCBBAA);
    for (int k = 0; k < 4; k++) begin
      chk("t1r_we",   32'(bwe[k+1]),  32'd0);
      chk("t1r_addr", 32'(badr[k+1]), 32'(8'h10 + k));
    end
    done_rsp("t1r");

    // byte read @11
    run(1'b0, 2'b00, 8'h11, 32'h0);
    chk("t2_lat", 32'(lat), 32'd3);
    chk("t2_rdata", rd, 32'h000000BB);
    done_rsp("t2");

    // half read @12 (aligned)
    run(1'b0, 2'b01, 8'h12, 32'h0);
    chk("t2h_lat", 32'(lat), 32'd4);
    chk("t2h_rdata", rd, 32'h0000DDCC);
    done_rsp("t2h");

`ifndef MEM_CTRL_ALIGN_CHECK_EN
    // wrapping word write @FE, wrapping half read @FF
    run(1'b1, 2'b10, 8'hFE, 32'h44332211);
    chk("t3w_lat", 32'(lat), 32'd5);
    chk("t3w_a0", 32'(badr[1]), 32'h0FE);
    chk("t3w_a1", 32'(badr[2]), 32'h0FF);
    chk("t3w_a2", 32'(badr[3]), 32'h000);
    chk("t3w_a3", 32'(badr[4]), 32'h001);
    chk("t3w_d2", 32'(bwd[3]),  32'h033);
    done_rsp("t3w");
    run(1'b0, 2'b01, 8'hFF, 32'h0);
    chk("t3h_lat", 32'(lat), 32'd4);
    chk("t3h_rdata", rd, 32'h00003322);
    done_rsp("t3h");
    run(1'b0, 2'b00, 8'h01, 32'h0);
    chk("t3b_rdata", rd, 32'h00000044);
    done_rsp("t3b");
`else
    run(1'b1, 2'b10, 8'hFE, 32'h44332211);
    chk("t3w_rej_lat", 32'(lat), 32'd1);
    chk("t3w_rej_err", 32'(er), 32'd1);
    chk("t3w_rej_we", 32'(bwe[1]), 32'd0);
    done_rsp("t3w");
`endif

    // response back-pressure
    run(1'b0, 2'b10, 8'h10, 32'h0);
    chk("t4_lat", 32'(lat), 32'd6);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_vld",   32'(rsp_valid), 32'd1);
      chk("t4_hold_rdata", rsp_rdata,      32'hDDCCBBAA);
      chk("t4_hold_rdy",   32'(req_ready), 32'd0);
      chk("t4_hold_we",    32'(mem_we),    32'd0);
    end
    req_valid = 1'b0;
    done_rsp("t4");

    // reset during beat 2 of a word write @20
    run(1'b1, 2'b10, 8'h20, 32'hEEEEEEEE);
    done_rsp("t5pre");
    req_write = 1'b1;
    req_size  = 2'b10;
    req_addr  = 8'h20;
    req_wdata = 32'h87654321;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_beat2_addr", 32'(mem_addr), 32'h22);
    chk("t5_beat2_we",   32'(mem_we),   32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_we",  32'(mem_we),    32'd0);
    chk("t5_rst_rdy", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_post_rdy", 32'(req_ready), 32'd1);
    chk("t5_post_vld", 32'(rsp_valid), 32'd0);
    run(1'b0, 2'b10, 8'h20, 32'h0);
    chk("t5_rdata", rd, 32'hEEEE4321);
    done_rsp("t5r");

`ifdef MEM_CTRL_ALIGN_CHECK_EN
    run(1'b1, 2'b10, 8'h02, 32'hA5A4A3A2);
    chk("t6w_lat", 32'(lat), 32'd1);
    chk("t6w_err", 32'(er), 32'd1);
    chk("t6w_we",  32'(bwe[1]), 32'd0);
    done_rsp("t6w");
    run(1'b0, 2'b10, 8'h02, 32'h0);
    chk("t6r_lat", 32'(lat), 32'd1);
    chk("t6r_err", 32'(er), 32'd1);
    chk("t6r_rdata", rd, 32'd0);
    done_rsp("t6r");
    run(1'b0, 2'b11, 8'h10, 32'h0);
    chk("t6s_lat", 32'(lat), 32'd1);
    chk("t6s_err", 32'(er), 32'd1);
    done_rsp("t6s");
`else
    run(1'b1, 2'b10, 8'h02, 32'hA5A4A3A2);
    chk("t6w_lat", 32'(lat), 32'd5);
    chk("t6w_a0", 32'(badr[1]), 32'h02);
    chk("t6w_a3", 32'(badr[4]), 32'h05);
    done_rsp("t6w");
    run(1'b0, 2'b10, 8'h02, 32'h0);
    chk("t6r_lat", 32'(lat), 32'd6);
    chk("t6r_err", 32'(er), 32'd0);
    chk("t6r_rdata", rd, 32'hA5A4A3A2);
    done_rsp("t6r");
    run(1'b0, 2'b11, 8'h10, 32'h0);
    chk("t6s_lat", 32'(lat), 32'd6);
    chk("t6s_err", 32'(er), 32'd0);
    chk("t6s_rdata", rd, 32'hDDCCBBAA);
    done_rsp("t6s");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
